wired_cdb_slot_sched: RTL
=========================

# wired_cdb_slot_sched

Write-back slot scheduler for the two-bank CDB. Fixed-latency execution units reserve a CDB bank slot at issue time, L cycles ahead, through a per-bank reservation calendar, so their results never stall at the CDB arbiter. The block also publishes, each cycle, which banks are already reserved, so the CDB arbiter keeps variable-latency ports off those banks. It sits between the issue stage (requesters) and the CDB arbiter (consumer of `slot_busy_o`).

## Interface
- `REQ_CNT`, 4: number of fixed-latency issue requesters; port 0 has the highest priority.
- `MAX_LAT`, 8: largest legal write-back latency, in cycles.
- `LAT_W`, `$clog2(MAX_LAT+1)`: width of a latency field (derived).
- `IDX_W`, `$clog2(REQ_CNT)`: width of a requester index (derived).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `flush_i` in 1: pipeline flush; discards all reservations.
- `req_valid_i` in `REQ_CNT`: requester i asks for a slot this cycle.
- `req_lat_i` in `REQ_CNT`×`LAT_W`: write-back latency L; legal range is 1..`MAX_LAT`.
- `req_bank_i` in `REQ_CNT`: target ROB bank, equal to `wid[0]` of the instruction.
- `grant_o` out `REQ_CNT`: combinational; the reservation is accepted this cycle.
- `slot_busy_o` out 2: bank b is reserved for the current cycle.
- `slot_owner_o` out 2×`IDX_W`: requester index that owns the current-cycle reservation of bank b (debug and checker use).

## Operation
- Each bank has a calendar `cal[b][k]`, k = 0..`MAX_LAT`. Each entry is {valid, owner}. Entry k refers to cycle now+k.
- The calendar shifts every cycle: `cal'[k] = cal[k+1]`, and `cal'[MAX_LAT]` becomes empty.
- Requester i is a candidate when all of these hold:
  - `req_valid_i[i]`
  - 1 ≤ L ≤ `MAX_LAT`
  - `!cal[b][L].valid`
  - `!flush_i`
- Among candidates with identical (b, L), the lowest index wins. Candidates with a different L, or a different bank, never conflict.
- `grant_o[i]` is 1 exactly for the winning candidates.
- A granted request writes {1, i} into `cal'[b][L-1]`. The write merges with the shift, so the entry is visible as offset L-1 in the next cycle.
- An illegal latency (L = 0 or L > `MAX_LAT`) never gets a grant. An assertion fires if it is seen with valid=1.
- A requester without a grant must retry with the same L in a later cycle. The block keeps no request state.
- `slot_busy_o[b] = cal[b][0].valid`. `slot_owner_o[b] = cal[b][0].owner`, or 0 when the entry is not valid.
- Flush: all grants are 0 in the flush cycle, and every calendar entry is invalid in the next cycle.
- Reset: every calendar entry is cleared, so `slot_busy_o` = 0 and `slot_owner_o` = 0 from the first cycle after reset.

## Timing
- Grant latency: 0 cycles, combinational from the request inputs and calendar state.
- A request granted at cycle t with latency L gives `slot_busy_o[b]` = 1 and `slot_owner_o[b]` = i at exactly cycle t+L, for one cycle only.
- L = 1 is legal: the slot is reserved for the next cycle.
- The current-cycle slot (offset 0) is never grantable.
- `cal[MAX_LAT]` is always empty at the start of a cycle, so L = `MAX_LAT` is never blocked by an older reservation. It can only lose to a lower-index requester in the same cycle.
- A grant in the same cycle as a shift is handled in one update: the shift and the grant write never target the same entry.
- Reset while reservations are pending drops them silently. Requesters are reset in the same cycle.
- `flush_i` and `rst_n` = 0 together: reset dominates, with the same end result.

## Structure
- Shared package:
  - `WIRED_CDB_BANK_CNT = 2`
  - typedef `cdb_slot_t` = {`logic valid`, `logic [IDX_W-1:0] owner`}
  - latency-field width constant
- One natural sub-module, `wired_cdb_calendar`, instantiated once per bank. It holds the shift register, the merge write, and the offset-0 outputs. Its ports are `clk`, `rst_n`, `flush`, a per-requester write enable, the write latency and owner, and a lookup for "entry L occupied".
- Top level: bank split, fixed-priority resolution for identical (b, L), the legality check, and the assertions.

## Test plan
- Single request: port 2, L = 3, bank 1 at t = 10 → `grant_o` = 4'b0100; `slot_busy_o` = 2'b10 only at t = 13; `slot_owner_o[1]` = 2 at t = 13.
- Same-slot conflict: ports 0 and 3 request L = 2, bank 0 at t → `grant_o` = 4'b0001; port 3 retries L = 2 at t+1 → granted; `slot_busy_o[0]` = 1 at both t+2 and t+3, with owners 0 then 3.
- Calendar occupied: a grant at t for L = 4 on bank 0, then a request at t+1 for L = 3 on bank 0 → `grant_o` = 0; a request at t+1 for L = 3 on bank 1 → granted.
- Boundary latencies: L = 0 and L = 9 (`MAX_LAT` = 8) → no grant, assertion flagged; L = 8 → granted, busy exactly 8 cycles later; L = 1 → busy at the next cycle.
- Flush: three reservations pending with L = 2, 5 and 7, then `flush_i` pulse → the grant in the flush cycle is 0, and `slot_busy_o` stays 0 for the following 8 cycles.
- Reset mid-operation: reservations pending, then `rst_n` low for 1 cycle → `slot_busy_o` = 0 and `slot_owner_o` = 0 afterwards; a new request is granted normally in the first cycle after reset.

Source files
------------

// File: rtl/wired_cdb_slot_sched_pkg.sv
// Shared types and constants for the CDB write-back slot scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wired_cdb_slot_sched_pkg;

  localparam int WIRED_CDB_BANK_CNT = 2;
  localparam int WIRED_CDB_REQ_CNT  = 4;
  localparam int WIRED_CDB_MAX_LAT  = 8;
  localparam int WIRED_CDB_LAT_W    = $clog2(WIRED_CDB_MAX_LAT + 1);
  localparam int WIRED_CDB_IDX_W    = $clog2(WIRED_CDB_REQ_CNT);

  // One calendar entry: a reserved write-back slot and the requester owning it.
  typedef struct packed {
    logic                       valid;
    logic [WIRED_CDB_IDX_W-1:0] owner;
  } cdb_slot_t;

  // A latency is reservable only when it lands strictly in the future and inside the calendar.
  function automatic logic lat_legal(input logic [WIRED_CDB_LAT_W-1:0] lat);
    return (lat != '0) && (int'(lat) <= WIRED_CDB_MAX_LAT);
  endfunction

endpackage

// File: rtl/wired_cdb_slot_sched_calendar.sv
// Per-bank reservation calendar: shifts one slot per cycle and merges new reservations.
// Latency: a write with latency L appears at offset 0 exactly L cycles later.
// Backpressure: none; occupancy is exported so the requester side blocks conflicts.
module wired_cdb_calendar
  import wired_cdb_slot_sched_pkg::*;
#(
  parameter int REQ_CNT = WIRED_CDB_REQ_CNT,
  parameter int MAX_LAT = WIRED_CDB_MAX_LAT,
  parameter int LAT_W   = WIRED_CDB_LAT_W,
  parameter int IDX_W   = WIRED_CDB_IDX_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [REQ_CNT-1:0]       wr_en,
  input  logic [REQ_CNT*LAT_W-1:0] wr_lat,
  input  logic [REQ_CNT*IDX_W-1:0] wr_owner,
  output logic [MAX_LAT:0]         occupied,
  output logic                     busy,
  output logic [IDX_W-1:0]         owner
);

  // Offset MAX_LAT is always empty at the start of a cycle, so only offsets 0..MAX_LAT-1 are stored.
  cdb_slot_t cal_q [MAX_LAT];
  cdb_slot_t cal_d [MAX_LAT];

  // Shift by one and drop each granted reservation into offset L-1 (never the shifted-in slot).
  always_comb begin
    for (int k = 0; k < MAX_LAT - 1; k++) cal_d[k] = cal_q[k+1];
    cal_d[MAX_LAT-1] = '0;
    for (int i = 0; i < REQ_CNT; i++) begin
      for (int k = 0; k < MAX_LAT; k++) begin
        if (wr_en[i] && (int'(wr_lat[i*LAT_W +: LAT_W]) == k + 1)) begin
          cal_d[k].valid = 1'b1;
          cal_d[k].owner = wr_owner[i*IDX_W +: IDX_W];
        end
      end
    end
  end

  // Calendar state; reset and flush both discard every pending reservation.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int k = 0; k < MAX_LAT; k++) cal_q[k] <= '0;
    end else begin
      for (int k = 0; k < MAX_LAT; k++) cal_q[k] <= cal_d[k];
    end
  end

  // Occupancy lookup per offset plus the current-cycle slot view.
  always_comb begin
    occupied = '0;
    for (int k = 0; k < MAX_LAT; k++) occupied[k] = cal_q[k].valid;
    busy  = cal_q[0].valid;
    owner = cal_q[0].valid ? cal_q[0].owner : '0;
  end

endmodule

// File: rtl/wired_cdb_slot_sched.sv
// Reserves CDB bank write-back slots L cycles ahead for fixed-latency units; publishes per-bank busy.
// Latency: grant is combinational; reserved slot shows on slot_busy_o exactly L cycles after grant.
// Backpressure: an ungranted requester retries later with the same L; no request state is held.
module wired_cdb_slot_sched
  import wired_cdb_slot_sched_pkg::*;
#(
  parameter int REQ_CNT = WIRED_CDB_REQ_CNT,
  parameter int MAX_LAT = WIRED_CDB_MAX_LAT,
  parameter int LAT_W   = $clog2(MAX_LAT + 1),
  parameter int IDX_W   = $clog2(REQ_CNT)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush_i,
  input  logic [REQ_CNT-1:0]                  req_valid_i,
  input  logic [REQ_CNT*LAT_W-1:0]            req_lat_i,
  input  logic [REQ_CNT-1:0]                  req_bank_i,
  output logic [REQ_CNT-1:0]                  grant_o,
  output logic [WIRED_CDB_BANK_CNT-1:0]       slot_busy_o,
  output logic [WIRED_CDB_BANK_CNT*IDX_W-1:0] slot_owner_o
);

  logic [MAX_LAT:0]     occ       [WIRED_CDB_BANK_CNT];
  logic [REQ_CNT-1:0]   bank_wr_en [WIRED_CDB_BANK_CNT];
  logic [REQ_CNT-1:0]   lat_illegal;
  logic [REQ_CNT-1:0]   cand;
  logic [REQ_CNT*IDX_W-1:0] owner_idx;

  // Candidate = valid, legal latency, target offset free in its bank, no flush.
  always_comb begin
    lat_illegal = '0;
    cand        = '0;
    for (int i = 0; i < REQ_CNT; i++) begin
      logic hit;
      hit = 1'b0;
      for (int k = 0; k <= MAX_LAT; k++) begin
        if (int'(req_lat_i[i*LAT_W +: LAT_W]) == k) hit = occ[req_bank_i[i]][k];
      end
      lat_illegal[i] = req_valid_i[i] && !lat_legal(req_lat_i[i*LAT_W +: LAT_W]);
      cand[i] = req_valid_i[i] && lat_legal(req_lat_i[i*LAT_W +: LAT_W]) && !hit && !flush_i;
    end
  end

  // Fixed priority only among candidates aiming at the same (bank, latency) slot.
  always_comb begin
    grant_o = '0;
    for (int i = 0; i < REQ_CNT; i++) begin
      grant_o[i] = cand[i];
      for (int j = 0; j < i; j++) begin
        if (cand[j] && (req_bank_i[j] == req_bank_i[i]) &&
            (req_lat_i[j*LAT_W +: LAT_W] == req_lat_i[i*LAT_W +: LAT_W]))
          grant_o[i] = 1'b0;
      end
    end
  end

  // Route each grant to the calendar of its target bank.
  always_comb begin
    bank_wr_en[0] = grant_o & ~req_bank_i;
    bank_wr_en[1] = grant_o &  req_bank_i;
  end

  for (genvar i = 0; i < REQ_CNT; i++) begin : g_owner
    assign owner_idx[i*IDX_W +: IDX_W] = IDX_W'(i);
  end

  for (genvar b = 0; b < WIRED_CDB_BANK_CNT; b++) begin : g_bank
    wired_cdb_calendar #(
      .REQ_CNT (REQ_CNT),
      .MAX_LAT (MAX_LAT),
      .LAT_W   (LAT_W),
      .IDX_W   (IDX_W)
    ) u_cal (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush_i),
      .wr_en    (bank_wr_en[b]),
      .wr_lat   (req_lat_i),
      .wr_owner (owner_idx),
      .occupied (occ[b]),
      .busy     (slot_busy_o[b]),
      .owner    (slot_owner_o[b*IDX_W +: IDX_W])
    );
  end

  // Flag any valid request whose latency can never be scheduled.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < REQ_CNT; i++) begin
        assert (!lat_illegal[i])
          else $warning("requester %0d: write-back latency outside 1..%0d", i, MAX_LAT);
      end
    end
  end

endmodule
